cp_exec: RTL and testbench
==========================

CP_EXEC -- requirements
Module: cp_exec

Interface
REQ-001 Parameter XLEN, default riscv::XLEN, datapath width.
REQ-002 Parameter MUL_CYC, default XLEN, multiply iterations; legal values: 1 to XLEN, where XLEN is divisible by MUL_CYC.
REQ-003 clk  in  1  sole clock; all state is updated on its rising edge.
REQ-004 arst  in  1  reset, asynchronous, active-high.
REQ-005 dq_val  in  1  dispatch-queue head entry valid.
REQ-006 dq_rdy  out  1  cp_exec accepts head entry; a pop occurs when dq_val and dq_rdy are both high.
REQ-007 dq_instr  in  32  low 32 bits of the instruction.
REQ-008 dq_rd_val  in  1  instruction writes rd.
REQ-009 dq_opa, dq_opb  in  XLEN  rs1/rs2 operand values.
REQ-010 cp_res_val  out  1  result valid to core.
REQ-011 cp_res_rdy  in  1  core accepts result.
REQ-012 cp_res_rd  out  5  destination register index.
REQ-013 cp_res  out  XLEN  result data.
REQ-014 cp_cmpl_instr_val  out  1  one-cycle instruction-complete pulse.
REQ-015 cp_busy  out  1  high whenever state is not IDLE.

Function
REQ-016 Op select is funct3 = dq_instr[14:12]:
- 000 ADD
- 001 SUB
- 010 AND
- 011 XOR
- 100 MUL (low XLEN bits of the product)
- 101 POPCNT(opa), zero-extended
- 110/111 unsupported: result 0, instruction still completes.
REQ-017 ADD/SUB wrap modulo 2^XLEN; MUL operands are treated as unsigned.
REQ-018 FSM states are IDLE, MUL, RESP; dq_rdy = (state == IDLE), combinational.
REQ-019 On a pop of a non-MUL op, the result is registered at edge N+1; next state is RESP if dq_rd_val=1, otherwise IDLE.
REQ-020 For a non-MUL op with dq_rd_val=0, cp_cmpl_instr_val pulses in cycle N+1 and no result is presented.
REQ-021 On a pop of a MUL op, operands are loaded, the iteration counter is cleared, and next state is MUL.
REQ-022 In MUL, one iteration completes per cycle, XLEN/MUL_CYC multiplier bits per iteration, for MUL_CYC cycles.
REQ-023 At the end of MUL, next state is RESP if rd_val, otherwise IDLE with the cp_cmpl_instr_val pulse.
REQ-024 Latency from pop to cp_res_val=1: non-MUL 1 cycle; MUL MUL_CYC+1 cycles.
REQ-025 In RESP, cp_res_val=1, and cp_res/cp_res_rd stay stable until cp_res_val & cp_res_rdy.
REQ-026 On that result handshake, cp_cmpl_instr_val pulses in the same cycle and next state is IDLE.
REQ-027 cp_res_rdy=1 on entry to RESP completes the handshake in the first RESP cycle.
REQ-028 cp_res_rdy held low keeps RESP indefinitely; no new pop occurs.
REQ-029 Throughput: at most one instruction in flight; back-to-back non-MUL ops with rdy=1 sustain one instruction per 2 cycles.
REQ-030 cp_res_val is 0 outside RESP; cp_res and cp_res_rd hold their last values.
REQ-031 dq_val deasserting while in IDLE has no effect; inputs are sampled only on a pop.

Reset
REQ-032 While arst is high: state=IDLE, counter=0, cp_res_val=0, cp_res=0, cp_res_rd=0, cp_cmpl_instr_val=0, cp_busy=0.
REQ-033 Reset asserted mid-MUL or mid-RESP discards the instruction; no result and no completion are produced after release.
REQ-034 The first pop is possible in the first cycle after arst deasserts.

Structure
REQ-035 Package cp_pkg holds the cp_op_e funct3 encodings, the cp_exec_state_e enum, and BOPC_CUSTOM0/1.
REQ-036 Sub-module cp_mul_iter, parameterised by XLEN and MUL_CYC, contains the iterative shift-add multiplier.
REQ-037 cp_mul_iter has ports start, opa, opb, done, prod.

Verification
REQ-038 ADD, opa=5, opb=7, rd=3, rdy=1 -> cp_res_val at N+1, cp_res=12, cp_res_rd=3, cmpl pulse at N+1.
REQ-039 SUB, opa=0, opb=1 -> cp_res = all ones (wrap).
REQ-040 MUL, opa=0xFFFF, opb=0x10001, MUL_CYC=XLEN -> cp_res=0xFFFFFFFF at cycle N+XLEN+1; dq_rdy=0 throughout.
REQ-041 POPCNT opa=0xF0F0, cp_res_rdy low 10 cycles -> cp_res_val held with cp_res=8 stable; cmpl only on the handshake cycle.
REQ-042 XOR with dq_rd_val=0 -> no cp_res_val, cmpl pulse at N+1; then funct3=111 -> cp_res=0, completes.
REQ-043 arst pulsed at MUL iteration 5 -> all outputs 0, no cmpl afterward; next ADD completes normally.

Source files
------------

// File: rtl/cp_pkg.sv
// Shared encodings for the custom-op executor: datapath width, funct3 op codes,
// FSM states and the custom-0/1 major opcodes.
package cp_pkg;

  localparam int CP_XLEN = 32;

  localparam logic [6:0] BOPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] BOPC_CUSTOM1 = 7'b0101011;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_XOR    = 3'b011,
    OP_MUL    = 3'b100,
    OP_POPCNT = 3'b101
  } cp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } cp_exec_state_e;

endpackage

// File: rtl/cp_mul_iter.sv
// Iterative unsigned shift-add multiplier: XLEN/MUL_CYC multiplier bits per cycle,
// MUL_CYC cycles after start. prod is the final sum, valid while done is high.
module cp_mul_iter #(
  parameter int XLEN    = cp_pkg::CP_XLEN,
  parameter int MUL_CYC = XLEN
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            start,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            done,
  output logic [XLEN-1:0] prod
);

  localparam int BITS = XLEN / MUL_CYC;
  localparam int CW   = $clog2(MUL_CYC + 1);

  logic            r_act;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] w_acc_nxt;

  always_comb begin
    w_acc_nxt = r_acc;
    for (int j = 0; j < BITS; j++) begin
      if (r_mplier[j]) w_acc_nxt = w_acc_nxt + (r_mcand << j);
    end
  end

  assign done = r_act && (r_cnt == CW'(MUL_CYC - 1));
  assign prod = w_acc_nxt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_act    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_act    <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= opa;
      r_mplier <= opb;
    end else if (r_act) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << BITS;
      r_mplier <= r_mplier >> BITS;
      r_cnt    <= r_cnt + CW'(1);
      if (done) r_act <= 1'b0;
    end
  end

endmodule

// File: rtl/cp_exec.sv
// Single-issue custom-op executor. States: IDLE wait for pop | MUL multiplier
// iterating | RESP result held until the core accepts it.
module cp_exec import cp_pkg::*; #(
  parameter int XLEN    = CP_XLEN,
  parameter int MUL_CYC = XLEN
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            dq_val,
  output logic            dq_rdy,
  input  logic [31:0]     dq_instr,
  input  logic            dq_rd_val,
  input  logic [XLEN-1:0] dq_opa,
  input  logic [XLEN-1:0] dq_opb,
  output logic            cp_res_val,
  input  logic            cp_res_rdy,
  output logic [4:0]      cp_res_rd,
  output logic [XLEN-1:0] cp_res,
  output logic            cp_cmpl_instr_val,
  output logic            cp_busy
);

  cp_exec_state_e r_state, w_state_nxt;
  logic            r_cmpl, r_rd_val;
  logic [4:0]      r_mul_rd, r_res_rd, w_rd_nxt;
  logic [XLEN-1:0] r_res, w_res_nxt, w_alu, w_popcnt, w_mul_prod;
  logic            w_pop, w_is_mul, w_mul_done, w_res_ld, w_cmpl_nxt;
  logic            w_unused;

  assign w_unused = ^{dq_instr[31:15], dq_instr[6:0]};
  assign w_pop    = dq_val && (r_state == ST_IDLE);
  assign w_is_mul = (dq_instr[14:12] == OP_MUL);

  always_comb begin
    w_alu    = '0;
    w_popcnt = '0;
    for (int i = 0; i < XLEN; i++) w_popcnt = w_popcnt + XLEN'(dq_opa[i]);
    case (cp_op_e'(dq_instr[14:12]))
      OP_ADD:    w_alu = dq_opa + dq_opb;
      OP_SUB:    w_alu = dq_opa - dq_opb;
      OP_AND:    w_alu = dq_opa & dq_opb;
      OP_XOR:    w_alu = dq_opa ^ dq_opb;
      OP_POPCNT: w_alu = w_popcnt;
      default:   w_alu = '0;
    endcase
  end

  cp_mul_iter #(.XLEN(XLEN), .MUL_CYC(MUL_CYC)) u_mul (
    .clk   (clk),
    .arst  (arst),
    .start (w_pop && w_is_mul),
    .opa   (dq_opa),
    .opb   (dq_opb),
    .done  (w_mul_done),
    .prod  (w_mul_prod)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_res_ld    = 1'b0;
    w_res_nxt   = w_alu;
    w_rd_nxt    = dq_instr[11:7];
    w_cmpl_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          if (w_is_mul) begin
            w_state_nxt = ST_MUL;
          end else if (dq_rd_val) begin
            w_state_nxt = ST_RESP;
            w_res_ld    = 1'b1;
          end else begin
            w_cmpl_nxt  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          if (r_rd_val) begin
            w_state_nxt = ST_RESP;
            w_res_ld    = 1'b1;
            w_res_nxt   = w_mul_prod;
            w_rd_nxt    = r_mul_rd;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cmpl_nxt  = 1'b1;
          end
        end
      end
      ST_RESP: if (cp_res_rdy) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // cp_res/cp_res_rd only change when a result is about to be presented
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state  <= ST_IDLE;
      r_cmpl   <= 1'b0;
      r_rd_val <= 1'b0;
      r_mul_rd <= '0;
      r_res    <= '0;
      r_res_rd <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cmpl  <= w_cmpl_nxt;
      if (w_pop && w_is_mul) begin
        r_rd_val <= dq_rd_val;
        r_mul_rd <= dq_instr[11:7];
      end
      if (w_res_ld) begin
        r_res    <= w_res_nxt;
        r_res_rd <= w_rd_nxt;
      end
    end
  end

  assign dq_rdy            = (r_state == ST_IDLE);
  assign cp_res_val        = (r_state == ST_RESP);
  assign cp_res            = r_res;
  assign cp_res_rd         = r_res_rd;
  assign cp_busy           = (r_state != ST_IDLE);
  assign cp_cmpl_instr_val = r_cmpl | (cp_res_val & cp_res_rdy);

endmodule

// File: tb/tb_cp_exec.sv
// Bench for cp_exec: directed scenarios plus random ops against an arithmetic model.
module tb_cp_exec;

  localparam int XLEN    = 32;
  localparam int MUL_CYC = 32;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic            dq_val = 1'b0;
  logic            dq_rdy;
  logic [31:0]     dq_instr = '0;
  logic            dq_rd_val = 1'b0;
  logic [XLEN-1:0] dq_opa = '0;
  logic [XLEN-1:0] dq_opb = '0;
  logic            cp_res_val;
  logic            cp_res_rdy = 1'b1;
  logic [4:0]      cp_res_rd;
  logic [XLEN-1:0] cp_res;
  logic            cp_cmpl_instr_val;
  logic            cp_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cp_exec #(.XLEN(XLEN), .MUL_CYC(MUL_CYC)) dut (
    .clk               (clk),
    .arst              (arst),
    .dq_val            (dq_val),
    .dq_rdy            (dq_rdy),
    .dq_instr          (dq_instr),
    .dq_rd_val         (dq_rd_val),
    .dq_opa            (dq_opa),
    .dq_opb            (dq_opb),
    .cp_res_val        (cp_res_val),
    .cp_res_rdy        (cp_res_rdy),
    .cp_res_rd         (cp_res_rd),
    .cp_res            (cp_res),
    .cp_cmpl_instr_val (cp_cmpl_instr_val),
    .cp_busy           (cp_busy)
  );

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f3)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a ^ b;
      3'd4: begin p = 64'(a) * 64'(b); return p[31:0]; end
      3'd5: return 32'($countones(a));
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3);
    return (f3 == 3'd4) ? MUL_CYC + 1 : 1;
  endfunction

  // Issues one instruction and observes it: cycle numbers are counted from the pop cycle (0).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rdval, input int stall,
                        output int lat, output logic [31:0] res, output logic [4:0] rdo,
                        output int cmpl, output bit rdy_issue, output bit busy_ok,
                        output bit stable, output bit post_ok);
    int cyc;
    bit done;
    lat = -1; cmpl = -1; res = '0; rdo = '0;
    busy_ok = 1'b1; stable = 1'b1; post_ok = 1'b0; done = 1'b0; cyc = 0;
    @(negedge clk);
    rdy_issue  = (dq_rdy === 1'b1);
    dq_val     = 1'b1;
    dq_instr   = {17'($urandom), f3, rd, 7'b0001011};
    dq_opa     = a;
    dq_opb     = b;
    dq_rd_val  = rdval;
    cp_res_rdy = (stall == 0);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      dq_val    = 1'b0;
      dq_instr  = $urandom;
      dq_opa    = $urandom;
      dq_opb    = $urandom;
      dq_rd_val = 1'($urandom);
      if (cp_res_val === 1'b1 && lat < 0) begin
        lat = cyc; res = cp_res; rdo = cp_res_rd;
      end
      if (lat >= 0 && cmpl < 0 && (cp_res_val !== 1'b1 || cp_res !== res || cp_res_rd !== rdo))
        stable = 1'b0;
      if (cp_cmpl_instr_val === 1'b1 && cmpl < 0) cmpl = cyc;
      if (lat < 0 && cmpl < 0 && (dq_rdy !== 1'b0 || cp_busy !== 1'b1)) busy_ok = 1'b0;
      if (lat >= 0 && cmpl < 0 && cyc - lat == stall && cp_res_rdy == 1'b0) begin
        cp_res_rdy = 1'b1;
        #1;
        if (cp_cmpl_instr_val === 1'b1) cmpl = cyc;
      end
      if (cmpl >= 0) done = 1'b1;
    end
    if (done) begin
      @(negedge clk);
      post_ok = (cp_res_val === 1'b0 && cp_cmpl_instr_val === 1'b0 && dq_rdy === 1'b1 && cp_busy === 1'b0);
    end
    cp_res_rdy = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (cp_res_val !== 1'b0) begin n_fail++; $display("FAIL reset_res_val: got %b expected 0", cp_res_val); end
    n_checks++; if (cp_res !== '0) begin n_fail++; $display("FAIL reset_res: got %0h expected 0", cp_res); end
    n_checks++; if (cp_res_rd !== 5'd0) begin n_fail++; $display("FAIL reset_res_rd: got %0d expected 0", cp_res_rd); end
    n_checks++; if (cp_cmpl_instr_val !== 1'b0) begin n_fail++; $display("FAIL reset_cmpl: got %b expected 0", cp_cmpl_instr_val); end
    n_checks++; if (cp_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", cp_busy); end
    n_checks++; if (dq_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_dq_rdy: got %b expected 1", dq_rdy); end
    @(posedge clk); #1;
    arst = 1'b0;
  endtask

  task automatic test_add();
    int lat, cmpl; logic [31:0] res; logic [4:0] rdo; bit ri, bo, st, po;
    run_op(3'd0, 32'd5, 32'd7, 5'd3, 1'b1, 0, lat, res, rdo, cmpl, ri, bo, st, po);
    n_checks++; if (ri !== 1'b1) begin n_fail++; $display("FAIL add_first_pop_rdy: got %b expected 1", ri); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_lat: got %0d expected 1", lat); end
    n_checks++; if (res !== 32'd12) begin n_fail++; $display("FAIL add_res: got %0h expected c", res); end
    n_checks++; if (rdo !== 5'd3) begin n_fail++; $display("FAIL add_rd: got %0d expected 3", rdo); end
    n_checks++; if (cmpl !== 1) begin n_fail++; $display("FAIL add_cmpl: got %0d expected 1", cmpl); end
    n_checks++; if (po !== 1'b1) begin n_fail++; $display("FAIL add_post_idle: got %b expected 1", po); end
  endtask

  task automatic test_sub();
    int lat, cmpl; logic [31:0] res; logic [4:0] rdo; bit ri, bo, st, po;
    run_op(3'd1, 32'd0, 32'd1, 5'd12, 1'b1, 0, lat, res, rdo, cmpl, ri, bo, st, po);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub_wrap: got %0h expected ffffffff", res); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sub_lat: got %0d expected 1", lat); end
  endtask

  task automatic test_mul();
    int lat, cmpl; logic [31:0] res; logic [4:0] rdo; bit ri, bo, st, po;
    run_op(3'd4, 32'h0000_FFFF, 32'h0001_0001, 5'd9, 1'b1, 0, lat, res, rdo, cmpl, ri, bo, st, po);
    n_checks++; if (lat !== MUL_CYC + 1) begin n_fail++; $display("FAIL mul_lat: got %0d expected %0d", lat, MUL_CYC + 1); end
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mul_res: got %0h expected ffffffff", res); end
    n_checks++; if (rdo !== 5'd9) begin n_fail++; $display("FAIL mul_rd: got %0d expected 9", rdo); end
    n_checks++; if (bo !== 1'b1) begin n_fail++; $display("FAIL mul_dq_rdy_low: got %b expected 1", bo); end
    n_checks++; if (cmpl !== MUL_CYC + 1) begin n_fail++; $display("FAIL mul_cmpl: got %0d expected %0d", cmpl, MUL_CYC + 1); end
  endtask

  task automatic test_popcnt_stall();
    int lat, cmpl; logic [31:0] res; logic [4:0] rdo; bit ri, bo, st, po;
    run_op(3'd5, 32'h0000_F0F0, $urandom, 5'd17, 1'b1, 10, lat, res, rdo, cmpl, ri, bo, st, po);
    n_checks++; if (res !== 32'd8) begin n_fail++; $display("FAIL popcnt_res: got %0h expected 8", res); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL popcnt_stable: got %b expected 1", st); end
    n_checks++; if (cmpl !== 11) begin n_fail++; $display("FAIL popcnt_cmpl_cycle: got %0d expected 11", cmpl); end
    n_checks++; if (po !== 1'b1) begin n_fail++; $display("FAIL popcnt_post_idle: got %b expected 1", po); end
  endtask

  task automatic test_no_rd();
    int lat, cmpl; logic [31:0] res; logic [4:0] rdo; bit ri, bo, st, po;
    run_op(3'd3, 32'h1234_5678, 32'h0F0F_0F0F, 5'd6, 1'b0, 0, lat, res, rdo, cmpl, ri, bo, st, po);
    n_checks++; if (lat !== -1) begin n_fail++; $display("FAIL xor_nord_res_val: got %0d expected -1", lat); end
    n_checks++; if (cmpl !== 1) begin n_fail++; $display("FAIL xor_nord_cmpl: got %0d expected 1", cmpl); end
    n_checks++; if (cp_res !== 32'd8) begin n_fail++; $display("FAIL xor_nord_res_hold: got %0h expected 8", cp_res); end
    run_op(3'd7, 32'hDEAD_BEEF, 32'h1111_2222, 5'd5, 1'b1, 0, lat, res, rdo, cmpl, ri, bo, st, po);
    n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL unsupported_res: got %0h expected 0", res); end
    n_checks++; if (cmpl !== 1) begin n_fail++; $display("FAIL unsupported_cmpl: got %0d expected 1", cmpl); end
    n_checks++; if (rdo !== 5'd5) begin n_fail++; $display("FAIL unsupported_rd: got %0d expected 5", rdo); end
  endtask

  task automatic test_random();
    int lat, cmpl, stall, xl; logic [31:0] res, a, b, xr; logic [4:0] rdo, rd; bit ri, bo, st, po;
    logic [2:0] f3; logic rv;
    for (int k = 0; k < 24; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a = (k % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
      b = (k % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      rd = 5'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      stall = $urandom_range(0, 3);
      xr = ref_res(f3, a, b);
      xl = ref_lat(f3);
      run_op(f3, a, b, rd, rv, stall, lat, res, rdo, cmpl, ri, bo, st, po);
      if (rv) begin
        n_checks++; if (res !== xr) begin n_fail++; $display("FAIL rand_res f3=%0d a=%0h b=%0h: got %0h expected %0h", f3, a, b, res, xr); end
        n_checks++; if (lat !== xl) begin n_fail++; $display("FAIL rand_lat f3=%0d: got %0d expected %0d", f3, lat, xl); end
        n_checks++; if (rdo !== rd) begin n_fail++; $display("FAIL rand_rd: got %0d expected %0d", rdo, rd); end
        n_checks++; if (cmpl !== xl + stall) begin n_fail++; $display("FAIL rand_cmpl f3=%0d: got %0d expected %0d", f3, cmpl, xl + stall); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL rand_stable: got %b expected 1", st); end
      end else begin
        n_checks++; if (lat !== -1) begin n_fail++; $display("FAIL rand_nord_res_val f3=%0d: got %0d expected -1", f3, lat); end
        n_checks++; if (cmpl !== xl) begin n_fail++; $display("FAIL rand_nord_cmpl f3=%0d: got %0d expected %0d", f3, cmpl, xl); end
      end
      n_checks++; if (bo !== 1'b1) begin n_fail++; $display("FAIL rand_busy f3=%0d: got %b expected 1", f3, bo); end
      n_checks++; if (po !== 1'b1) begin n_fail++; $display("FAIL rand_post_idle f3=%0d: got %b expected 1", f3, po); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [4:0] qrd[$];
    logic [31:0] a, b, er;
    logic [4:0] rd, erd;
    logic [2:0] f3;
    int pops, nres;
    pops = 0; nres = 0;
    cp_res_rdy = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 20; c++) begin
      if (cp_res_val === 1'b1) begin
        nres++;
        er = (q.size() > 0) ? q.pop_front() : 32'hX;
        erd = (qrd.size() > 0) ? qrd.pop_front() : 5'hX;
        n_checks++; if (cp_res !== er) begin n_fail++; $display("FAIL b2b_res: got %0h expected %0h", cp_res, er); end
        n_checks++; if (cp_res_rd !== erd) begin n_fail++; $display("FAIL b2b_rd: got %0d expected %0d", cp_res_rd, erd); end
      end
      if (c == 20) break;
      a = $urandom; b = $urandom; rd = 5'($urandom); f3 = 3'($urandom_range(0, 3));
      dq_val = 1'b1; dq_instr = {17'($urandom), f3, rd, 7'b0001011};
      dq_opa = a; dq_opb = b; dq_rd_val = 1'b1;
      #1;
      if (dq_rdy === 1'b1) begin pops++; q.push_back(ref_res(f3, a, b)); qrd.push_back(rd); end
      @(negedge clk);
    end
    dq_val = 1'b0;
    n_checks++; if (pops !== 10) begin n_fail++; $display("FAIL b2b_pops: got %0d expected 10", pops); end
    n_checks++; if (nres !== 10) begin n_fail++; $display("FAIL b2b_results: got %0d expected 10", nres); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int lat, cmpl; logic [31:0] res; logic [4:0] rdo; bit ri, bo, st, po, seen;
    run_op(3'd0, 32'd5, 32'd9, 5'd31, 1'b1, 0, lat, res, rdo, cmpl, ri, bo, st, po);
    @(negedge clk);
    dq_val = 1'b1; dq_instr = {17'd0, 3'd4, 5'd4, 7'b0001011};
    dq_opa = $urandom | 32'd1; dq_opb = $urandom | 32'd1; dq_rd_val = 1'b1;
    @(negedge clk);
    dq_val = 1'b0;
    repeat (5) @(negedge clk);
    arst = 1'b1;
    #1;
    n_checks++; if (cp_res !== '0) begin n_fail++; $display("FAIL midmul_res: got %0h expected 0", cp_res); end
    n_checks++; if (cp_res_rd !== 5'd0) begin n_fail++; $display("FAIL midmul_rd: got %0d expected 0", cp_res_rd); end
    n_checks++; if (cp_busy !== 1'b0) begin n_fail++; $display("FAIL midmul_busy: got %b expected 0", cp_busy); end
    n_checks++; if (cp_res_val !== 1'b0 || cp_cmpl_instr_val !== 1'b0) begin n_fail++; $display("FAIL midmul_val_cmpl: got %b%b expected 00", cp_res_val, cp_cmpl_instr_val); end
    @(posedge clk); #1;
    arst = 1'b0;
    seen = 1'b0;
    repeat (MUL_CYC + 8) begin
      @(negedge clk);
      if (cp_res_val !== 1'b0 || cp_cmpl_instr_val !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midmul_ghost_completion: got %b expected 0", seen); end
    run_op(3'd0, 32'h0000_0100, 32'h0000_0023, 5'd2, 1'b1, 0, lat, res, rdo, cmpl, ri, bo, st, po);
    n_checks++; if (res !== 32'h0000_0123) begin n_fail++; $display("FAIL midmul_next_add: got %0h expected 123", res); end
    n_checks++; if (cmpl !== 1) begin n_fail++; $display("FAIL midmul_next_cmpl: got %0d expected 1", cmpl); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_popcnt_stall();
    test_no_rd();
    test_random();
    test_back_to_back();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
